// File: rtl/gpioemu_host_seq_if.sv
// gpioemu_host_seq_if: command/response handshakes plus the gpioemu register bus
interface gpioemu_host_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_a1;
   logic [23:0] cmd_a2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_w;
   logic [23:0] rsp_l;
   logic        rsp_timeout;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_out;
   logic [31:0] sdata_in;
   modport master (
      input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
      output cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_timeout, saddress, srd, swr, sdata_out
   );
   modport slave (
      output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
      input  cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_timeout, saddress, srd, swr, sdata_out
   );
endinterface

// File: rtl/gpioemu_host_seq.sv
// gpioemu_host_seq: runs write A1/A2/CTRL, status poll, read W/L on the gpioemu bus per command
module gpioemu_host_seq #(
   parameter logic [15:0] ADDR_A1   = 16'h0380,
   parameter logic [15:0] ADDR_A2   = 16'h0388,
   parameter logic [15:0] ADDR_W    = 16'h0390,
   parameter logic [15:0] ADDR_L    = 16'h0398,
   parameter logic [15:0] ADDR_CTRL = 16'h03A0,
   parameter int          STROBE_W  = 2,
   parameter int          GAP_W     = 2,
   parameter int          POLL_MAX  = 1024
) (
   input  logic                 clk,
   input  logic                 n_reset,
   gpioemu_host_seq_if.master   bus,
   output logic [15:0]          op_count
);
   typedef enum logic [2:0] {IDLE, WR_A1, WR_A2, WR_GO, RD_STAT, RD_W, RD_L, RESP} state_t;
   localparam int LAST = STROBE_W + GAP_W;
   localparam int PW   = $clog2(POLL_MAX + 1);
   state_t        state;
   logic [15:0]   cnt;
   logic [15:0]   cnt_n;
   logic [PW-1:0] poll;
   logic [1:0]    stat;
   logic [23:0]   a2;
   logic          last;
   logic          strobe_n;
   logic          wr_st;
   logic          rd_st;
   logic          cap;
   // cnt walks SETUP (0), STROBE (1..STROBE_W), HOLD (..LAST) within every access
   assign last     = cnt == 16'(LAST);
   assign cnt_n    = last ? '0 : cnt + 16'd1;
   assign strobe_n = cnt_n != '0 && cnt_n <= 16'(STROBE_W);
   assign wr_st    = state inside {WR_A1, WR_A2, WR_GO};
   assign rd_st    = state inside {RD_STAT, RD_W, RD_L};
   assign cap      = rd_st && cnt == 16'(STROBE_W + 1);
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state           <= IDLE;
         cnt             <= '0;
         poll            <= '0;
         stat            <= '0;
         a2              <= '0;
         op_count        <= '0;
         bus.cmd_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_w       <= '0;
         bus.rsp_l       <= '0;
         bus.rsp_timeout <= 1'b0;
         bus.saddress    <= '0;
         bus.srd         <= 1'b0;
         bus.swr         <= 1'b0;
         bus.sdata_out   <= '0;
      end else begin
         cnt     <= (wr_st || rd_st) ? cnt_n : '0;
         bus.srd <= rd_st && strobe_n;
         bus.swr <= wr_st && strobe_n;
         if (cap && state == RD_STAT) begin
            stat <= bus.sdata_in[1:0];
            poll <= poll + 1'b1;
         end
         if (cap && state == RD_W) bus.rsp_w <= bus.sdata_in;
         if (cap && state == RD_L) bus.rsp_l <= bus.sdata_in[23:0];
         case (state)
            IDLE: if (bus.cmd_valid) begin
               state           <= WR_A1;
               a2              <= bus.cmd_a2;
               poll            <= '0;
               bus.cmd_ready   <= 1'b0;
               bus.rsp_w       <= '0;
               bus.rsp_l       <= '0;
               bus.rsp_timeout <= 1'b0;
               bus.saddress    <= ADDR_A1;
               bus.sdata_out   <= {8'h0, bus.cmd_a1};
            end
            WR_A1: if (last) begin
               state         <= WR_A2;
               bus.saddress  <= ADDR_A2;
               bus.sdata_out <= {8'h0, a2};
            end
            WR_A2: if (last) begin
               state         <= WR_GO;
               bus.saddress  <= ADDR_CTRL;
               bus.sdata_out <= '0;
            end
            WR_GO: if (last) state <= RD_STAT;
            RD_STAT: if (last) begin
               if (stat == 2'b11) begin
                  state        <= RD_W;
                  bus.saddress <= ADDR_W;
               end else if (poll == PW'(POLL_MAX)) begin
                  state           <= RESP;
                  bus.rsp_timeout <= 1'b1;
                  bus.rsp_valid   <= 1'b1;
               end
            end
            RD_W: if (last) begin
               state        <= RD_L;
               bus.saddress <= ADDR_L;
            end
            RD_L: if (last) begin
               state         <= RESP;
               bus.rsp_valid <= 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
               state         <= IDLE;
               bus.rsp_valid <= 1'b0;
               bus.cmd_ready <= 1'b1;
               op_count      <= op_count + 16'd1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gpioemu_host_seq.sv
// tb_gpioemu_host_seq: gpioemu peripheral model, bus-order scoreboard and directed commands
module tb_gpioemu_host_seq;
   localparam int S  = 2;
   localparam int G  = 2;
   localparam int PM = 8;
   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] op_count;
   gpioemu_host_seq_if bus();
   gpioemu_host_seq #(.POLL_MAX(PM)) dut (.clk(clk), .n_reset(n_reset), .bus(bus), .op_count(op_count));
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask
   function automatic logic [63:0] ent(input logic [15:0] a, input logic w, input logic [31:0] d);
      return {a, w, 15'h0, d};
   endfunction
   // peripheral model: product/popcount of the operands, status 01 for busy_polls reads then 11
   logic [23:0] pa1 = '0, pa2 = '0;
   logic [47:0] prod;
   int          busy_polls = 0, pstat = 0;
   logic        srd_q = 1'b0, swr_q = 1'b0;
   logic [63:0] log_q[$];
   assign prod = 48'(pa1) * 48'(pa2);
   always @(posedge clk) begin
      srd_q <= bus.srd;
      swr_q <= bus.swr;
      if (bus.swr && !swr_q) begin
         log_q.push_back(ent(bus.saddress, 1'b1, bus.sdata_out));
         if (bus.saddress == 16'h0380) pa1 <= bus.sdata_out[23:0];
         if (bus.saddress == 16'h0388) pa2 <= bus.sdata_out[23:0];
         if (bus.saddress == 16'h03A0) pstat <= 0;
      end
      if (bus.srd && !srd_q) begin
         log_q.push_back(ent(bus.saddress, 1'b0, bus.sdata_out));
         if (bus.saddress == 16'h0390) bus.sdata_in <= prod[31:0];
         else if (bus.saddress == 16'h0398) bus.sdata_in <= 32'($countones(prod));
         else if (bus.saddress == 16'h03A0) begin
            bus.sdata_in <= (pstat >= busy_polls) ? 32'h3 : 32'h1;
            pstat <= pstat + 1;
         end else bus.sdata_in <= '0;
      end
   end
   // strobe width check, measured at negedges while out of reset
   int slen = 0;
   always @(negedge clk) begin
      if (!n_reset) slen = 0;
      else if (bus.srd || bus.swr) slen++;
      else if (slen != 0) begin
         chk("strobe_width", 64'(slen), 64'(S));
         slen = 0;
      end
   end
   // per-cycle compare against the expected response and operation count
   logic [31:0] exp_w = '0;
   logic [23:0] exp_l = '0;
   logic        exp_to = 1'b0;
   logic [15:0] exp_ops = '0;
   always @(negedge clk) begin
      if (n_reset) begin
         chk("op_count", op_count, exp_ops);
         chk("one_strobe", bus.srd & bus.swr, 0);
         if (bus.rsp_valid) begin
            chk("rsp_w", bus.rsp_w, exp_w);
            chk("rsp_l", bus.rsp_l, exp_l);
            chk("rsp_timeout", bus.rsp_timeout, exp_to);
         end
      end
   end
   logic [31:0] got_w;
   logic [23:0] got_l;
   logic        got_to;
   int          got_nstat, got_nres, got_lat;
   task automatic run_cmd(input logic [23:0] a1, input logic [23:0] a2, input int busy, input int hold, input bit lat_chk);
      int          k, t0, nst;
      logic [47:0] p;
      logic [63:0] exq[$];
      p = 48'(a1) * 48'(a2);
      exp_to = busy >= PM;
      exp_w = exp_to ? 32'h0 : p[31:0];
      exp_l = exp_to ? 24'h0 : 24'($countones(p));
      busy_polls = busy;
      nst = exp_to ? PM : busy + 1;
      exq = {ent(16'h0380, 1'b1, {8'h0, a1}), ent(16'h0388, 1'b1, {8'h0, a2}), ent(16'h03A0, 1'b1, 32'h0)};
      for (int i = 0; i < nst; i++) exq.push_back(ent(16'h03A0, 1'b0, 32'h0));
      if (!exp_to) begin
         exq.push_back(ent(16'h0390, 1'b0, 32'h0));
         exq.push_back(ent(16'h0398, 1'b0, 32'h0));
      end
      @(negedge clk);
      k = 0;
      while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
      chk("cmd_ready_before_cmd", bus.cmd_ready, 1);
      log_q.delete();
      bus.cmd_a1 = a1;
      bus.cmd_a2 = a2;
      bus.cmd_valid = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      chk("cmd_ready_busy", bus.cmd_ready, 0);
      k = 0;
      @(negedge clk);
      while (!bus.rsp_valid && k < 2000) begin @(negedge clk); k++; end
      chk("rsp_valid_seen", bus.rsp_valid, 1);
      got_lat = cyc - t0;
      if (lat_chk) chk("latency", 64'(got_lat), 64'(6 * (1 + S + G) + 1));
      got_w = bus.rsp_w;
      got_l = bus.rsp_l;
      got_to = bus.rsp_timeout;
      if (hold > 0) begin
         bus.cmd_a1 = 24'h111111;
         bus.cmd_a2 = 24'h222222;
         bus.cmd_valid = 1'b1;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         repeat (hold - 1) @(negedge clk);
         chk("rsp_valid_held", bus.rsp_valid, 1);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      exp_ops++;
      #1 bus.rsp_ready = 1'b0;
      chk("rsp_valid_dropped", bus.rsp_valid, 0);
      chk("cmd_ready_after_accept", bus.cmd_ready, 1);
      if (hold > 0) begin
         repeat (3) @(negedge clk);
         chk("ignored_cmd_idle", bus.cmd_ready, 1);
      end
      chk("bus_len", 64'(log_q.size()), 64'(exq.size()));
      for (int i = 0; i < exq.size() && i < log_q.size(); i++) chk($sformatf("bus_op_%0d", i), log_q[i], exq[i]);
      got_nstat = 0;
      got_nres = 0;
      foreach (log_q[i]) begin
         if (log_q[i][63:48] == 16'h03A0 && !log_q[i][47]) got_nstat++;
         if (log_q[i][63:48] == 16'h0390 || log_q[i][63:48] == 16'h0398) got_nres++;
      end
   endtask
   initial begin
      int k;
      bus.cmd_valid = 1'b0;
      bus.cmd_a1 = '0;
      bus.cmd_a2 = '0;
      bus.rsp_ready = 1'b0;
      bus.sdata_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_outputs", {bus.rsp_valid, bus.rsp_w, bus.rsp_l, bus.rsp_timeout, bus.srd, bus.swr}, 0);
      chk("rst_bus", {bus.saddress, bus.sdata_out, op_count}, 0);
      n_reset = 1'b1;
      // reset in the middle of the first write strobe
      @(negedge clk);
      bus.cmd_a1 = 24'h7;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      k = 0;
      while (!bus.swr && k < 50) begin @(posedge clk); #1 k++; end
      chk("mid_strobe_reached", bus.swr, 1);
      #2 n_reset = 1'b0;
      #1 chk("async_rst_strobes", {bus.srd, bus.swr}, 0);
      chk("async_rst_cmd_ready", bus.cmd_ready, 1);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      chk("post_rst_op_count", op_count, 0);
      chk("post_rst_idle", {bus.cmd_ready, bus.srd, bus.swr}, 3'b100);
      run_cmd(24'd3, 24'd5, 0, 0, 1'b1);
      chk("t2_w", got_w, 32'd15);
      chk("t2_l", got_l, 24'd4);
      chk("t2_timeout", got_to, 0);
      chk("t2_latency", 64'(got_lat), 31);
      run_cmd(24'hFFFFFF, 24'h000100, 7, 0, 1'b0);
      chk("t3_w", got_w, 32'hFFFFFF00);
      chk("t3_l", got_l, 24'd24);
      chk("t3_polls", 64'(got_nstat), 8);
      run_cmd(24'd5, 24'd6, 100000, 0, 1'b0);
      chk("t4_timeout", got_to, 1);
      chk("t4_wl", {got_w, got_l}, 0);
      chk("t4_polls", 64'(got_nstat), 8);
      chk("t4_no_result_reads", 64'(got_nres), 0);
      run_cmd(24'd9, 24'd10, 0, 10, 1'b0);
      chk("t5_w", got_w, 32'd90);
      chk("t5_op_count", op_count, 16'd4);
      run_cmd(24'h123456, 24'hABCDEF, 0, 0, 1'b1);
      run_cmd(24'h800001, 24'h000003, 2, 0, 1'b0);
      chk("b2b_w", got_w, 32'h01800003);
      chk("b2b_l", got_l, 24'd4);
      @(posedge clk);
      #1 force dut.op_count = 16'hFFFF;
      exp_ops = 16'hFFFF;
      #1 release dut.op_count;
      run_cmd(24'd2, 24'd2, 0, 0, 1'b0);
      chk("t6_wrap", op_count, 16'h0000);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
